// File: rtl/ysyx_24080006_icache.sv
// rtl/ysyx_24080006_icache.sv - direct-mapped read-only I-cache with AXI4 line refill
// Optional uncached low region (4'h0) enabled by YSYX_24080006_ICACHE_BYPASS_EN.
module ysyx_24080006_icache #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        fence_i,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);
  localparam int WB  = $clog2(LINE_WORDS);
  localparam int OFF = 2 + WB;
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 32 - IDX - OFF;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_AR, S_R, S_RESP} state_t;
  state_t state, state_next;

  logic [31:2]     addr_q;
  logic [WB-1:0]   beat_q;
  logic            err_q;
  logic            fence_seen_q;
  logic [31:0]     word_q;
  logic            word_err_q;
  logic [SETS-1:0] valid_q;
  logic [TAG-1:0]  tag_arr  [SETS];
  logic [31:0]     data_arr [SETS*LINE_WORDS];

  logic [IDX-1:0]  idx;
  logic [WB-1:0]   woff;
  logic [TAG-1:0]  tag_in;
  logic [31:0]     hit_word;
  logic            bypass;
  logic            hit;
  logic            burst_end;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  assign idx      = addr_q[OFF+IDX-1:OFF];
  assign woff     = addr_q[OFF-1:2];
  assign tag_in   = addr_q[31:32-TAG];
  assign hit_word = data_arr[{idx, woff}];

`ifdef YSYX_24080006_ICACHE_BYPASS_EN
  assign bypass = (addr_q[31:28] == 4'h0);
`else
  assign bypass = 1'b0;
`endif

  // A fence in the lookup cycle must not let a stale line answer.
  assign hit       = valid_q[idx] && (tag_arr[idx] == tag_in) && !bypass && !fence_i;
  assign burst_end = (state == S_R) && rvalid &&
                     (rlast || (beat_q == WB'(LINE_WORDS - 1)) || bypass);

  assign arid    = 4'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlen   = bypass ? 8'd0 : 8'(LINE_WORDS - 1);

  always_comb begin
    araddr = 32'd0;
    if (state == S_AR) begin
      if (bypass) araddr = {addr_q[31:2], 2'b00};
      else        araddr = {addr_q[31:OFF], {OFF{1'b0}}};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = word_q;
    rsp_err    = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          rsp_valid  = 1'b1;
          rsp_data   = hit_word;
          state_next = rsp_ready ? S_IDLE : S_RESP;
        end else begin
          state_next = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_next = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (burst_end) state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = word_err_q;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q       <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      fence_seen_q <= 1'b0;
      word_q       <= 32'd0;
      word_err_q   <= 1'b0;
      valid_q      <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        addr_q       <= req_addr[31:2];
        fence_seen_q <= 1'b0;
      end
      if (state == S_LOOKUP && hit) begin
        word_q     <= hit_word;
        word_err_q <= 1'b0;
      end
      if (state == S_AR && arready) begin
        beat_q <= '0;
        err_q  <= 1'b0;
      end
      if (state == S_R && rvalid) begin
        beat_q <= beat_q + WB'(1);
        if (rresp != 2'b00) err_q <= 1'b1;
        if (bypass || beat_q == woff) word_q <= rdata;
        if (burst_end) begin
          word_err_q <= err_q | (rresp != 2'b00);
          if (!bypass && !err_q && rresp == 2'b00 && !fence_seen_q && !fence_i)
            valid_q[idx] <= 1'b1;
        end
      end
      // Invalidation wins over any same-edge validation.
      if (fence_i) begin
        fence_seen_q <= 1'b1;
        valid_q      <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && state == S_R && rvalid && !bypass) begin
      data_arr[{idx, beat_q}] <= rdata;
      if (burst_end) tag_arr[idx] <= tag_in;
    end
  end
endmodule

// File: tb/tb_ysyx_24080006_icache.sv
// tb/tb_ysyx_24080006_icache.sv - directed self-checking bench for ysyx_24080006_icache
module tb_ysyx_24080006_icache;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        fence_i;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int total = 0;
  int bad   = 0;

  ysyx_24080006_icache dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .fence_i(fence_i),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic accept(input logic [31:0] a);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic serve_ar(input logic [31:0] exp_addr, input logic [7:0] exp_len, input int delay);
    int n = 0;
    while (arvalid !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("ar_seen", arvalid, 1'b1);
    check("araddr", araddr, exp_addr);
    check("arlen", arlen, exp_len);
    check("arburst", arburst, 2'b01);
    check("arsize_arid", {arsize, arid}, {3'b010, 4'd0});
    for (int d = 0; d < delay; d++) begin
      arready = 1'b0;
      @(negedge clock);
      check("ar_hold_valid", arvalid, 1'b1);
      check("ar_hold_addr", araddr, exp_addr);
      check("ar_hold_req_ready", req_ready, 1'b0);
    end
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
  endtask

  task automatic serve_r(input logic [31:0] base, input int err_beat, input int gap,
                         input int fence_beat, input bit use_last, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      for (int g = 0; g < gap; g++) begin
        rvalid = 1'b0;
        @(negedge clock);
        check("r_gap_req_ready", req_ready, 1'b0);
        check("r_gap_rsp_valid", rsp_valid, 1'b0);
      end
      check("rready", rready, 1'b1);
      rvalid  = 1'b1;
      rdata   = base + i;
      rresp   = (i == err_beat) ? 2'b10 : 2'b00;
      rlast   = use_last && (i == nbeats - 1);
      fence_i = (i == fence_beat);
      @(negedge clock);
      rvalid  = 1'b0;
      rresp   = 2'b00;
      rlast   = 1'b0;
      fence_i = 1'b0;
    end
  endtask

  task automatic get_rsp(input logic [31:0] exp_data, input logic exp_err, input int hold);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", rsp_err, exp_err);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      @(negedge clock);
      check("rsp_hold_valid", rsp_valid, 1'b1);
      check("rsp_hold_data", rsp_data, exp_data);
      check("rsp_hold_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("back_to_idle", req_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b0; fence_i = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_araddr", araddr, 32'd0);

    // Cold miss then hit in the same line
    accept(32'h3000_0004);
    check("cold_miss", rsp_valid, 1'b0);
    serve_ar(32'h3000_0000, 8'd3, 0);
    serve_r(32'hA0, -1, 0, -1, 1'b1, 4);
    get_rsp(32'hA1, 1'b0, 0);
    accept(32'h3000_000C);
    check("hit_latency", rsp_valid, 1'b1);
    check("hit_no_ar", arvalid, 1'b0);
    get_rsp(32'hA3, 1'b0, 0);

    // Conflict on index 0
    accept(32'h3000_0100);
    check("conflict_miss", rsp_valid, 1'b0);
    serve_ar(32'h3000_0100, 8'd3, 0);
    serve_r(32'hB0, -1, 0, -1, 1'b1, 4);
    get_rsp(32'hB0, 1'b0, 0);
    accept(32'h3000_0000);
    check("evicted_miss", rsp_valid, 1'b0);
    serve_ar(32'h3000_0000, 8'd3, 0);
    serve_r(32'hA0, -1, 0, -1, 1'b1, 4);
    get_rsp(32'hA0, 1'b0, 0);

    // Error beat leaves the line invalid
    accept(32'h3000_0044);
    serve_ar(32'h3000_0040, 8'd3, 0);
    serve_r(32'hC0, 1, 0, -1, 1'b1, 4);
    get_rsp(32'hC1, 1'b1, 0);
    accept(32'h3000_0040);
    check("err_line_miss", rsp_valid, 1'b0);
    serve_ar(32'h3000_0040, 8'd3, 0);
    serve_r(32'hD0, -1, 0, -1, 1'b1, 4);
    get_rsp(32'hD0, 1'b0, 0);
    accept(32'h3000_004C);
    check("refilled_hit", rsp_valid, 1'b1);
    get_rsp(32'hD3, 1'b0, 0);

    // fence_i during refill
    accept(32'h3000_0084);
    serve_ar(32'h3000_0080, 8'd3, 0);
    serve_r(32'hE0, -1, 0, 2, 1'b1, 4);
    get_rsp(32'hE1, 1'b0, 0);
    accept(32'h3000_0080);
    check("fenced_line_miss", rsp_valid, 1'b0);
    serve_ar(32'h3000_0080, 8'd3, 0);
    serve_r(32'hF0, -1, 0, -1, 1'b1, 4);
    get_rsp(32'hF0, 1'b0, 0);
    accept(32'h3000_0000);
    check("fence_other_miss", rsp_valid, 1'b0);
    serve_ar(32'h3000_0000, 8'd3, 0);
    serve_r(32'hA0, -1, 0, -1, 1'b1, 4);
    get_rsp(32'hA0, 1'b0, 0);

    // Back-pressure everywhere, burst without rlast
    accept(32'h3000_00C8);
    serve_ar(32'h3000_00C0, 8'd3, 5);
    serve_r(32'h50, -1, 2, -1, 1'b0, 4);
    get_rsp(32'h52, 1'b0, 3);
    accept(32'h3000_00C4);
    check("no_rlast_hit", rsp_valid, 1'b1);
    get_rsp(32'h51, 1'b0, 0);

    // Low region: uncached with the bypass macro, cached otherwise
`ifdef YSYX_24080006_ICACHE_BYPASS_EN
    accept(32'h0F00_0008);
    serve_ar(32'h0F00_0008, 8'd0, 0);
    serve_r(32'h60, -1, 0, -1, 1'b1, 1);
    get_rsp(32'h60, 1'b0, 0);
    accept(32'h0F00_0008);
    check("bypass_refetch", rsp_valid, 1'b0);
    serve_ar(32'h0F00_0008, 8'd0, 0);
    serve_r(32'h70, -1, 0, -1, 1'b1, 1);
    get_rsp(32'h70, 1'b0, 0);
`else
    accept(32'h0F00_0008);
    serve_ar(32'h0F00_0000, 8'd3, 0);
    serve_r(32'h60, -1, 0, -1, 1'b1, 4);
    get_rsp(32'h62, 1'b0, 0);
    accept(32'h0F00_0008);
    check("low_region_hit", rsp_valid, 1'b1);
    get_rsp(32'h62, 1'b0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
